// File: rtl/sensor_hub_pkg.sv
// Shared definitions for the sensor hub: FSM state codes, request/command
// codes, error codes and small command-decoding helpers.
`timescale 1ns/1ps
package sensor_hub_pkg;

    typedef logic [7:0] hub_byte_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GET_ADDR  = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_DISPATCH  = 3'd3;
    localparam logic [2:0] ST_SEND      = 3'd4;
    localparam logic [2:0] ST_POLL_WAIT = 3'd5;

    localparam hub_byte_t CMD_READ_A = 8'h01;
    localparam hub_byte_t CMD_READ_B = 8'h02;
    localparam hub_byte_t CMD_ARM_A  = 8'h03;
    localparam hub_byte_t CMD_ARM_B  = 8'h04;
    localparam hub_byte_t CMD_STOP   = 8'h05;

    localparam hub_byte_t ERR_FLAG     = 8'h80;
    localparam hub_byte_t ERR_BAD_CMD  = 8'hE1;
    localparam hub_byte_t ERR_BAD_ADDR = 8'hE2;
    localparam hub_byte_t ERR_TIMEOUT  = 8'hE3;

    function automatic logic cmd_is_valid(input hub_byte_t c);
        return (c >= CMD_READ_A) && (c <= CMD_STOP);
    endfunction

    function automatic logic cmd_arms(input hub_byte_t c);
        return (c == CMD_ARM_A) || (c == CMD_ARM_B);
    endfunction

    // Arming commands are forwarded to the sensor as the plain read they wrap.
    function automatic hub_byte_t cmd_to_request(input hub_byte_t c);
        case (c)
            CMD_ARM_A: return CMD_READ_A;
            CMD_ARM_B: return CMD_READ_B;
            default:   return c;
        endcase
    endfunction

endpackage

// File: rtl/sensor_hub_timer.sv
// Saturating down-counter: load a start value, count while enabled, and flag
// expiry once the count has reached zero.
`timescale 1ns/1ps
module sensor_hub_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count,
    output logic             expire
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = count && (cnt_q == '0);

endmodule

// File: rtl/sensor_hub.sv
// Byte-oriented request/response front end that selects one of NUM_DEVICES
// sensors, collects its result and streams the reply, with optional polling.
`timescale 1ns/1ps
module sensor_hub
    import sensor_hub_pkg::*;
#(
    parameter int NUM_DEVICES    = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int BYTE_TIMEOUT   = 5_000_000,
    parameter int SENSOR_TIMEOUT = 50_000_000,
    parameter int POLL_PERIOD    = 100_000_000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic [NUM_DEVICES-1:0] dev_enable,
    output logic [7:0]             dev_request,
    input  logic [DATA_WIDTH-1:0]  dev_data,
    input  logic                   dev_done,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   continuous,
    output logic                   rx_overrun
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int RW   = (NB + 1) * 8;
    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int ST_W = $clog2(SENSOR_TIMEOUT + 1);
    localparam int PP_W = $clog2(POLL_PERIOD + 1);
    localparam int TW01 = (BT_W > ST_W) ? BT_W : ST_W;
    localparam int TW   = (TW01 > PP_W) ? TW01 : PP_W;

    logic [2:0]             state_q, state_d;
    hub_byte_t              cmd_q, cmd_d;
    hub_byte_t              addr_q, addr_d;
    hub_byte_t              poll_cmd_q, poll_cmd_d;
    hub_byte_t              poll_addr_q, poll_addr_d;
    logic                   cont_q, cont_d;
    logic                   ovr_q, ovr_d;
    logic [RW-1:0]          resp_q, resp_d;
    logic [2:0]             left_q, left_d;
    logic                   tx_valid_q, tx_valid_d;
    hub_byte_t              tx_data_q, tx_data_d;
    logic [NUM_DEVICES-1:0] dev_enable_q, dev_enable_d;
    hub_byte_t              dev_request_q, dev_request_d;

    logic                   load_resp;
    logic [RW-1:0]          new_resp;
    logic                   addr_bad;
    logic [NUM_DEVICES-1:0] dev_sel;

    logic                   tmr_load;
    logic                   tmr_count;
    logic [TW-1:0]          tmr_value;
    logic                   tmr_expire;

    // Byte, sensor and poll timeouts never overlap, so one counter serves all.
    sensor_hub_timer #(.WIDTH(TW)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .count      (tmr_count),
        .expire     (tmr_expire)
    );

    assign addr_bad = ({1'b0, addr_q} >= 9'(NUM_DEVICES));

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        poll_cmd_d  = poll_cmd_q;
        poll_addr_d = poll_addr_q;
        cont_d      = cont_q;
        ovr_d       = ovr_q;
        resp_d      = resp_q;
        left_d      = left_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        load_resp   = 1'b0;
        new_resp    = '0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    cmd_d   = rx_data;
                    ovr_d   = 1'b0;
                    state_d = ST_GET_ADDR;
                end
            end
            ST_GET_ADDR: begin
                if (tmr_expire) begin
                    if (rx_valid) ovr_d = 1'b1;
                    state_d = cont_q ? ST_POLL_WAIT : ST_IDLE;
                end else if (rx_valid) begin
                    addr_d  = rx_data;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rx_valid) ovr_d = 1'b1;
                if (!cmd_is_valid(cmd_q)) begin
                    load_resp             = 1'b1;
                    new_resp[RW-1 -: 8]   = cmd_q | ERR_FLAG;
                    new_resp[RW-9 -: 8]   = ERR_BAD_CMD;
                end else if (addr_bad) begin
                    load_resp             = 1'b1;
                    new_resp[RW-1 -: 8]   = cmd_q | ERR_FLAG;
                    new_resp[RW-9 -: 8]   = ERR_BAD_ADDR;
                end else if (cmd_q == CMD_STOP) begin
                    cont_d                = 1'b0;
                    load_resp             = 1'b1;
                    new_resp[RW-1 -: 8]   = cmd_q;
                end else begin
                    if (cmd_arms(cmd_q)) begin
                        cont_d      = 1'b1;
                        poll_cmd_d  = cmd_q;
                        poll_addr_d = addr_q;
                    end
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (rx_valid) ovr_d = 1'b1;
                if (dev_done) begin
                    load_resp = 1'b1;
                    new_resp  = {cmd_q, dev_data};
                end else if (tmr_expire) begin
                    cont_d                = 1'b0;
                    load_resp             = 1'b1;
                    new_resp[RW-1 -: 8]   = cmd_q | ERR_FLAG;
                    new_resp[RW-9 -: 8]   = ERR_TIMEOUT;
                end
            end
            ST_SEND: begin
                if (rx_valid) ovr_d = 1'b1;
                if (tx_valid_q && tx_ready) begin
                    if (left_q == 3'd0) begin
                        tx_valid_d = 1'b0;
                        state_d    = cont_q ? ST_POLL_WAIT : ST_IDLE;
                    end else begin
                        tx_data_d = resp_q[RW-1 -: 8];
                        resp_d    = resp_q << 8;
                        left_d    = left_q - 3'd1;
                    end
                end
            end
            ST_POLL_WAIT: begin
                if (tmr_expire) begin
                    if (rx_valid) ovr_d = 1'b1;
                    cmd_d   = poll_cmd_q;
                    addr_d  = poll_addr_q;
                    state_d = ST_DISPATCH;
                end else if (rx_valid) begin
                    cmd_d   = rx_data;
                    ovr_d   = 1'b0;
                    state_d = ST_GET_ADDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every response path enters SEND through here with its first byte staged.
        if (load_resp) begin
            state_d    = ST_SEND;
            tx_valid_d = 1'b1;
            tx_data_d  = new_resp[RW-1 -: 8];
            resp_d     = new_resp << 8;
            left_d     = 3'(NB);
        end
    end

    always_comb begin
        tmr_count = (state_q == ST_GET_ADDR) || (state_q == ST_DISPATCH) ||
                    (state_q == ST_POLL_WAIT);
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (state_d != state_q) begin
            case (state_d)
                ST_GET_ADDR: begin
                    tmr_load  = 1'b1;
                    tmr_value = TW'(BYTE_TIMEOUT - 1);
                end
                ST_DISPATCH: begin
                    tmr_load  = 1'b1;
                    tmr_value = TW'(SENSOR_TIMEOUT - 1);
                end
                ST_POLL_WAIT: begin
                    tmr_load  = 1'b1;
                    tmr_value = TW'(POLL_PERIOD - 1);
                end
                default: begin
                    tmr_load  = 1'b0;
                    tmr_value = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DEVICES; gi++) begin : g_sel
            assign dev_sel[gi] = (addr_d == 8'(gi));
        end
    endgenerate

    always_comb begin
        dev_enable_d  = '0;
        dev_request_d = '0;
        if (state_d == ST_DISPATCH) begin
            dev_enable_d  = dev_sel;
            dev_request_d = cmd_to_request(cmd_d);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            addr_q        <= '0;
            poll_cmd_q    <= '0;
            poll_addr_q   <= '0;
            cont_q        <= 1'b0;
            ovr_q         <= 1'b0;
            resp_q        <= '0;
            left_q        <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            dev_enable_q  <= '0;
            dev_request_q <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            poll_cmd_q    <= poll_cmd_d;
            poll_addr_q   <= poll_addr_d;
            cont_q        <= cont_d;
            ovr_q         <= ovr_d;
            resp_q        <= resp_d;
            left_q        <= left_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            dev_enable_q  <= dev_enable_d;
            dev_request_q <= dev_request_d;
        end
    end

    assign dev_enable  = dev_enable_q;
    assign dev_request = dev_request_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_POLL_WAIT);
    assign continuous  = cont_q;
    assign rx_overrun  = ovr_q;

endmodule

// File: tb/tb_sensor_hub.sv
// Directed bench for sensor_hub: request/response, error paths, timeouts,
// polling, overrun, TX back-pressure and asynchronous reset.
`timescale 1ns/1ps
module tb_sensor_hub;

    logic        clock;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] dev_enable;
    logic [7:0]  dev_request;
    logic [15:0] dev_data;
    logic        dev_done;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        continuous;
    logic        rx_overrun;

    int checks   = 0;
    int failures = 0;

    sensor_hub #(
        .NUM_DEVICES    (32),
        .DATA_WIDTH     (16),
        .BYTE_TIMEOUT   (50),
        .SENSOR_TIMEOUT (100),
        .POLL_PERIOD    (200)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .dev_enable  (dev_enable),
        .dev_request (dev_request),
        .dev_data    (dev_data),
        .dev_done    (dev_done),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .continuous  (continuous),
        .rx_overrun  (rx_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        $display("rx byte %02h", b);
    endtask

    // Waits (bounded) for a presented TX byte, checks it, and lets it transfer.
    task automatic get_byte(input string tag, input logic [7:0] exp);
        bit found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (tx_valid) found = 1;
            else step();
        end
        check({tag, " present"}, 64'(found), 64'd1);
        if (found) begin
            check(tag, 64'(tx_data), 64'(exp));
            $display("tx byte %02h (expected %02h)", tx_data, exp);
            step();
        end
    endtask

    task automatic pulse_done(input logic [15:0] d);
        dev_done = 1'b1;
        dev_data = d;
        step();
        dev_done = 1'b0;
        dev_data = 16'h0000;
    endtask

    initial begin
        int  n;
        bit  flag;

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        dev_data = 16'h0000;
        dev_done = 1'b0;
        tx_ready = 1'b1;
        step();
        step();
        check("reset dev_enable", 64'(dev_enable), 64'd0);
        check("reset dev_request", 64'(dev_request), 64'd0);
        check("reset tx_valid", 64'(tx_valid), 64'd0);
        check("reset tx_data", 64'(tx_data), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset continuous", 64'(continuous), 64'd0);
        check("reset rx_overrun", 64'(rx_overrun), 64'd0);
        reset_n = 1'b1;
        step();

        // Basic read: 0x01 to device 5, result after 20 cycles.
        send_byte(8'h01);
        send_byte(8'h05);
        check("check-cycle dev_enable", 64'(dev_enable), 64'd0);
        step();
        check("dispatch dev_enable", 64'(dev_enable), 64'h20);
        check("dispatch dev_request", 64'(dev_request), 64'h01);
        check("dispatch busy", 64'(busy), 64'd1);
        repeat (19) step();
        check("dispatch held", 64'(dev_enable), 64'h20);
        pulse_done(16'h1234);
        check("done dev_enable drop", 64'(dev_enable), 64'd0);
        check("done tx_valid", 64'(tx_valid), 64'd1);
        get_byte("read b0", 8'h01);
        get_byte("read b1", 8'h12);
        get_byte("read b2", 8'h34);
        check("read idle tx_valid", 64'(tx_valid), 64'd0);
        check("read idle busy", 64'(busy), 64'd0);

        // Invalid command and out-of-range addresses.
        send_byte(8'h07);
        send_byte(8'h00);
        get_byte("badcmd b0", 8'h87);
        get_byte("badcmd b1", 8'hE1);
        get_byte("badcmd b2", 8'h00);
        send_byte(8'h01);
        send_byte(8'h40);
        get_byte("badaddr b0", 8'h81);
        get_byte("badaddr b1", 8'hE2);
        get_byte("badaddr b2", 8'h00);
        send_byte(8'h02);
        send_byte(8'h20);
        get_byte("addr32 b0", 8'h82);
        get_byte("addr32 b1", 8'hE2);
        get_byte("addr32 b2", 8'h00);

        // Sensor timeout: enable held exactly 100 cycles.
        send_byte(8'h02);
        send_byte(8'h03);
        step();
        check("to dev_enable", 64'(dev_enable), 64'h08);
        repeat (99) step();
        check("to last enabled cycle", 64'(dev_enable), 64'h08);
        step();
        check("to dev_enable drop", 64'(dev_enable), 64'd0);
        get_byte("to b0", 8'h82);
        get_byte("to b1", 8'hE3);
        get_byte("to b2", 8'h00);

        // Continuous mode via 0x03 on device 2.
        send_byte(8'h03);
        send_byte(8'h02);
        step();
        check("cont dev_request", 64'(dev_request), 64'h01);
        pulse_done(16'hBEEF);
        get_byte("cont b0", 8'h03);
        get_byte("cont b1", 8'hBE);
        get_byte("cont b2", 8'hEF);
        check("cont armed", 64'(continuous), 64'd1);
        check("cont poll not busy", 64'(busy), 64'd0);
        for (int r = 0; r < 2; r++) begin
            n = 0;
            while (dev_enable == 32'd0 && n < 400) begin
                step();
                n++;
            end
            check("poll interval", 64'(n), 64'd200);
            check("poll dev_enable", 64'(dev_enable), 64'h04);
            pulse_done(16'h5678 + 16'(r));
            get_byte("poll b0", 8'h03);
            get_byte("poll b1", 8'h56);
            get_byte("poll b2", 8'h78 + 8'(r));
        end
        send_byte(8'h05);
        send_byte(8'h02);
        get_byte("stop b0", 8'h05);
        get_byte("stop b1", 8'h00);
        get_byte("stop b2", 8'h00);
        check("stop continuous", 64'(continuous), 64'd0);
        flag = 0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (dev_enable != 32'd0) flag = 1;
        end
        check("stop no redispatch", 64'(flag), 64'd0);

        // Byte timeout after a lone command byte.
        send_byte(8'h01);
        repeat (49) step();
        check("bto still waiting", 64'(busy), 64'd1);
        step();
        check("bto back to idle", 64'(busy), 64'd0);
        check("bto no tx", 64'(tx_valid), 64'd0);

        // Overrun during SEND plus TX back-pressure.
        tx_ready = 1'b0;
        send_byte(8'h07);
        send_byte(8'h00);
        step();
        check("bp tx_valid", 64'(tx_valid), 64'd1);
        send_byte(8'hAA);
        check("overrun set", 64'(rx_overrun), 64'd1);
        flag = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!(tx_valid === 1'b1 && tx_data === 8'h87)) flag = 0;
        end
        check("bp tx stable", 64'(flag), 64'd1);
        tx_ready = 1'b1;
        get_byte("bp b0", 8'h87);
        get_byte("bp b1", 8'hE1);
        get_byte("bp b2", 8'h00);
        check("overrun sticky", 64'(rx_overrun), 64'd1);
        send_byte(8'h01);
        check("overrun cleared", 64'(rx_overrun), 64'd0);
        send_byte(8'h07);
        step();
        check("dev7 enable", 64'(dev_enable), 64'h80);
        pulse_done(16'h00FF);
        get_byte("dev7 b0", 8'h01);
        get_byte("dev7 b1", 8'h00);
        get_byte("dev7 b2", 8'hFF);

        // Asynchronous reset in the middle of DISPATCH.
        send_byte(8'h02);
        send_byte(8'h01);
        step();
        check("pre-reset enable", 64'(dev_enable), 64'h02);
        #2 reset_n = 1'b0;
        #1;
        check("async reset enable", 64'(dev_enable), 64'd0);
        check("async reset busy", 64'(busy), 64'd0);
        step();
        reset_n = 1'b1;
        pulse_done(16'hDEAD);
        flag = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx_valid) flag = 1;
            step();
        end
        check("reset abort no tx", 64'(flag), 64'd0);

        // Highest device with arming command 0x04, then stop.
        send_byte(8'h04);
        send_byte(8'h1F);
        step();
        check("dev31 enable", 64'(dev_enable), 64'h8000_0000);
        check("dev31 request", 64'(dev_request), 64'h02);
        pulse_done(16'hA55A);
        get_byte("dev31 b0", 8'h04);
        get_byte("dev31 b1", 8'hA5);
        get_byte("dev31 b2", 8'h5A);
        check("dev31 armed", 64'(continuous), 64'd1);
        send_byte(8'h05);
        send_byte(8'h1F);
        get_byte("stop2 b0", 8'h05);
        get_byte("stop2 b1", 8'h00);
        get_byte("stop2 b2", 8'h00);
        check("stop2 continuous", 64'(continuous), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_hub.md
SENSOR_HUB -- requirements
Module: sensor_hub

Interface
REQ-001 Parameter NUM_DEVICES, default 32: number of addressable sensor channels, range 1..256.
REQ-002 Parameter DATA_WIDTH, default 16: sensor result width; a multiple of 8 in 8..32, sent as NB = DATA_WIDTH/8 bytes.
REQ-003 Parameter BYTE_TIMEOUT, default 5_000_000: maximum number of clock cycles allowed between the two request bytes.
REQ-004 Parameter SENSOR_TIMEOUT, default 50_000_000: maximum number of cycles from dev_enable assertion to dev_done.
REQ-005 Parameter POLL_PERIOD, default 100_000_000: continuous-mode re-issue interval, in cycles.
REQ-006 Ports (name  direction  width  meaning):
- clock  in  1  the single clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle pulse; a byte has been received.
- rx_data  in  8  received byte, valid only with rx_valid.
- dev_enable  out  NUM_DEVICES  one-hot select of the addressed sensor.
- dev_request  out  8  command code forwarded to the sensor.
- dev_data  in  DATA_WIDTH  result from the selected sensor.
- dev_done  in  1  one-cycle pulse; dev_data is valid.
- tx_valid  out  1  response byte available.
- tx_data  out  8  response byte.
- tx_ready  in  1  transmitter can accept a byte.
- busy  out  1  high in any state other than IDLE and POLL_WAIT.
- continuous  out  1  continuous mode is armed.
- rx_overrun  out  1  sticky flag; a byte was discarded.

Function
REQ-007 A request is two bytes: byte0 is the command, byte1 is the device address.
REQ-008 Commands:
- 0x01..0x02 are single reads.
- 0x03/0x04 are reads that also arm continuous mode for command 0x01/0x02 respectively.
- 0x05 disarms continuous mode; it gets no sensor access and responds {0x05, 0x00 x NB}.
- All other command codes are invalid.
REQ-009 The state machine has these states:
- IDLE: on rx_valid, capture byte0 and go to GET_ADDR.
- GET_ADDR: on rx_valid, capture byte1 and go to CHECK.
- CHECK: one cycle, then go to DISPATCH or to SEND with an error response.
- DISPATCH: dev_enable is held until dev_done or timeout.
- SEND: transmits 1+NB bytes.
- POLL_WAIT: counts down POLL_PERIOD, then returns to DISPATCH.
REQ-010 CHECK order: an invalid command produces response {cmd|0x80, 0xE1}; otherwise an address >= NUM_DEVICES produces {cmd|0x80, 0xE2}.
REQ-011 Error responses are padded with 0x00 to 1+NB bytes.
REQ-012 DISPATCH timing: dev_enable[addr] and dev_request shall assert on the cycle after CHECK.
REQ-013 In DISPATCH, dev_enable shall deassert in the cycle after dev_done; dev_data is captured on the dev_done cycle.
REQ-014 Success response: byte0 = cmd, then dev_data MSB byte first.
REQ-015 Sensor timeout: if dev_done is absent for SENSOR_TIMEOUT cycles, the block sends {cmd|0x80, 0xE3}, deasserts dev_enable, and disarms continuous mode.
REQ-016 Byte timeout: if byte1 is absent for BYTE_TIMEOUT cycles in GET_ADDR, the block drops the request with no response and goes to POLL_WAIT if continuous is armed, else to IDLE.
REQ-017 TX handshake: tx_valid/tx_data are held stable until a cycle with tx_ready=1, and a byte transfers on that edge.
REQ-018 The next TX byte is presented no earlier than the following cycle, and tx_valid is never asserted outside SEND.
REQ-019 tx_valid shall assert the cycle after dev_done.
REQ-020 After the last transfer in SEND, the block goes to POLL_WAIT if continuous is armed, else to IDLE.
REQ-021 In POLL_WAIT, rx_valid captures byte0, goes to GET_ADDR and abandons the countdown; continuous mode stays armed.
REQ-022 In continuous mode, the block re-dispatches the stored command and address on each POLL_PERIOD expiry.
REQ-023 rx_valid in CHECK, DISPATCH or SEND discards the byte and sets rx_overrun.
REQ-024 rx_overrun clears when the next byte0 is accepted.
REQ-025 rx_valid coinciding with a timeout expiry: the timeout wins and the byte is discarded (rx_overrun set).
REQ-026 dev_done outside DISPATCH is ignored.
REQ-027 All timeout counters are sized ceil(log2(max+1)) and saturate without wrapping.

Reset
REQ-028 On reset_n=0, asynchronously:
- The state machine enters IDLE.
- dev_enable=0, dev_request=0x00, tx_valid=0, tx_data=0x00.
- busy=0, continuous=0, rx_overrun=0.
- All counters and captured bytes are cleared.
REQ-029 A reset during DISPATCH or SEND aborts the operation with no further output.
REQ-030 After reset release, the first accepted byte is the byte0 of a new request.

Structure
REQ-031 Package sensor_hub_pkg shall hold the command codes, the error codes 0xE1/0xE2/0xE3, and the state encoding.
REQ-032 One sub-module, sensor_hub_timer (load, count, expire, parametrised width), shall be shared by the byte, sensor and poll timeouts.

Verification
REQ-033 Request 0x01,0x05 with dev_done at 20 cycles and dev_data=0x1234 (DATA_WIDTH=16) -> dev_enable[5]=1, then TX 0x01,0x12,0x34.
REQ-034 Request 0x07,0x00 -> TX 0x87,0xE1,0x00; request 0x01,0x40 with NUM_DEVICES=32 -> TX 0x81,0xE2,0x00.
REQ-035 Request 0x02,0x03 with no dev_done and SENSOR_TIMEOUT=100 -> dev_enable drops after 100 cycles, then TX 0x82,0xE3,0x00.
REQ-036 Request 0x03,0x02 with POLL_PERIOD=200 -> responses repeat every 200 cycles after SEND; then 0x05,0x02 -> TX 0x05,0x00,0x00 and continuous=0.
REQ-037 Byte 0x01 followed by silence with BYTE_TIMEOUT=50 -> return to IDLE with no TX; an extra byte during SEND -> rx_overrun=1; tx_ready held low for 10 cycles -> tx_data stable.
